// File: rtl/vuop_sequencer.sv
// -----------------------------------------------------------------------------
// vuop_sequencer
//
// Splits one decoded RV32V vector instruction into a stream of micro-ops.
// Each uop covers NUM_LANES consecutive elements. It carries its index within
// the instruction, the source and destination register offsets inside the
// register group, the bank position inside the source register, a per-lane
// active mask and a last flag.
//
// Optional feature macro: RV32V_VSTART_RESUME_EN
//   defined   : in_vstart is honoured. Uops wholly below vstart are skipped
//               and leading lanes below vstart are masked off.
//   undefined : in_vstart is ignored and sequencing always starts at 0.
//
// Ports
//   CLK, RST                      clock, synchronous active-high reset
//   flush                         abort the current sequence, block accept
//   in_valid / in_ready           instruction handshake (in_ready is comb)
//   in_vsew, in_vlmul, in_widen   element width, group multiplier, widening
//   in_vl, in_vstart              vector length, first element to process
//   uop_valid / uop_ready         uop handshake
//   uop_num                       uop index within instruction
//   uop_last                      final uop of instruction
//   uop_lane_active               lane i active when base+i in [vstart, vl)
//   uop_elem_base                 element index of lane 0
//   uop_vs_reg_off/uop_vd_reg_off source/destination register offset
//   uop_bank_offset               uop position within its source register
//   illegal                       one-cycle pulse after a rejected accept
// -----------------------------------------------------------------------------
module vuop_sequencer #(
   parameter  int VLEN      = 128,
   parameter  int NUM_LANES = 4,
   localparam int EW        = $clog2(VLEN) + 1,
   localparam int UW        = $clog2(VLEN / NUM_LANES),
   localparam int BW        = ($clog2(VLEN / (8 * NUM_LANES)) > 1) ?
                              $clog2(VLEN / (8 * NUM_LANES)) : 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           in_vsew,
   input  logic [2:0]           in_vlmul,
   input  logic                 in_widen,
   input  logic [EW-1:0]        in_vl,
   input  logic [EW-1:0]        in_vstart,
   output logic                 uop_valid,
   input  logic                 uop_ready,
   output logic [UW-1:0]        uop_num,
   output logic                 uop_last,
   output logic [NUM_LANES-1:0] uop_lane_active,
   output logic [EW-1:0]        uop_elem_base,
   output logic [2:0]           uop_vs_reg_off,
   output logic [2:0]           uop_vd_reg_off,
   output logic [BW-1:0]        uop_bank_offset,
   output logic                 illegal
);

   localparam int LOG_VLEN = $clog2(VLEN);
   localparam int LOG_NL   = $clog2(NUM_LANES);

   typedef enum logic {IDLE, SEQ} state_t;

   typedef struct packed {
      logic [NUM_LANES-1:0] lanes;
      logic                 last;
      logic [2:0]           vs_off;
      logic [2:0]           vd_off;
      logic [BW-1:0]        bank;
   } uop_fields_t;

   // Per-uop fields for a given lane-0 element index. Elements per register
   // is VLEN/(8<<vsew), so every divide below is a shift by its log2.
   // An empty instruction (vl==0 or vstart>=vl) needs no special case: all
   // lanes fall outside [s, vl) and base+NUM_LANES >= vl holds by itself.
   function automatic uop_fields_t calc_fields(
      input logic [EW-1:0] base,
      input logic [1:0]    vsew,
      input logic          widen,
      input logic [EW-1:0] vl,
      input logic [EW-1:0] s
   );
      uop_fields_t   f;
      int            log_epr;
      logic [EW-1:0] epr_mask;
      logic [EW:0]   elem;
      log_epr  = LOG_VLEN - 3 - int'(vsew);
      epr_mask = (EW'(1) << log_epr) - EW'(1);
      f.vs_off = 3'(base >> log_epr);
      f.vd_off = 3'(base >> (log_epr - int'(widen)));
      f.bank   = BW'((base & epr_mask) >> LOG_NL);
      f.last   = (({1'b0, base} + (EW+1)'(NUM_LANES)) >= {1'b0, vl});
      for (int i = 0; i < NUM_LANES; i++) begin
         elem       = {1'b0, base} + (EW+1)'(i);
         f.lanes[i] = (elem >= {1'b0, s}) && (elem < {1'b0, vl});
      end
      return f;
   endfunction

   // ---------------------------------------------------------------- state
   state_t               state_q;
   logic [EW-1:0]        base_q;
   logic [UW-1:0]        num_q;
   logic [1:0]           vsew_q;
   logic                 widen_q;
   logic [EW-1:0]        vl_q;
   logic [EW-1:0]        s_q;
   logic                 uop_valid_q;
   logic                 uop_last_q;
   logic [NUM_LANES-1:0] lanes_q;
   logic [2:0]           vs_off_q;
   logic [2:0]           vd_off_q;
   logic [BW-1:0]        bank_q;
   logic                 illegal_q;

   // ------------------------------------------------------ next-state terms
   logic [EW-1:0] s_d;
   logic [EW-1:0] start_base_d;
   logic [EW-1:0] adv_base_d;
   logic          accept;
   logic          acc_illegal;
   uop_fields_t   start_fields;
   uop_fields_t   adv_fields;

`ifdef RV32V_VSTART_RESUME_EN
   assign s_d = in_vstart;
`else
   // vstart is not honoured in this build; keep the port but sink it.
   logic unused_vstart;
   assign unused_vstart = ^in_vstart;
   assign s_d           = '0;
`endif

   // Combinational so a new instruction can be taken in the same cycle as
   // the previous instruction's last uop handshake (no bubble).
   assign in_ready = !flush &&
                     ((state_q == IDLE) || (uop_valid_q && uop_ready && uop_last_q));
   assign accept   = in_valid && in_ready;

   // NOTE: every signal driven in always_comb gets a value on every path
   // (here: unconditionally), otherwise the tool infers a latch.
   always_comb begin
      acc_illegal  = (in_vsew > 3'd2)                      // SEW64 and reserved
                  || (in_widen && (in_vsew == 3'd2))       // SEW32 cannot widen
                  || (in_widen && (in_vlmul == 3'd3))      // LMUL8 cannot widen
                  || (in_vlmul == 3'd4);                   // reserved LMUL
      // Round vstart down to a uop boundary: uops wholly below it are skipped.
      start_base_d = (s_d >> LOG_NL) << LOG_NL;
      adv_base_d   = base_q + EW'(NUM_LANES);
      start_fields = calc_fields(start_base_d, in_vsew[1:0], in_widen, in_vl, s_d);
      adv_fields   = calc_fields(adv_base_d, vsew_q, widen_q, vl_q, s_q);
   end

   // ------------------------------------------------------------------ FSM
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         base_q      <= '0;
         num_q       <= '0;
         vsew_q      <= '0;
         widen_q     <= 1'b0;
         vl_q        <= '0;
         s_q         <= '0;
         uop_valid_q <= 1'b0;
         uop_last_q  <= 1'b0;
         lanes_q     <= '0;
         vs_off_q    <= '0;
         vd_off_q    <= '0;
         bank_q      <= '0;
         illegal_q   <= 1'b0;
      end else begin
         illegal_q <= 1'b0;
         if (flush) begin
            // Drop the in-flight uop; in_ready is low so nothing is accepted.
            state_q     <= IDLE;
            uop_valid_q <= 1'b0;
         end else if (accept) begin
            if (acc_illegal) begin
               state_q     <= IDLE;
               uop_valid_q <= 1'b0;
               illegal_q   <= 1'b1;
            end else begin
               state_q     <= SEQ;
               base_q      <= start_base_d;
               num_q       <= '0;
               vsew_q      <= in_vsew[1:0];
               widen_q     <= in_widen;
               vl_q        <= in_vl;
               s_q         <= s_d;
               uop_valid_q <= 1'b1;
               uop_last_q  <= start_fields.last;
               lanes_q     <= start_fields.lanes;
               vs_off_q    <= start_fields.vs_off;
               vd_off_q    <= start_fields.vd_off;
               bank_q      <= start_fields.bank;
            end
         end else if ((state_q == SEQ) && uop_ready) begin
            if (uop_last_q) begin
               state_q     <= IDLE;
               uop_valid_q <= 1'b0;
            end else begin
               base_q      <= adv_base_d;
               num_q       <= num_q + UW'(1);
               uop_last_q  <= adv_fields.last;
               lanes_q     <= adv_fields.lanes;
               vs_off_q    <= adv_fields.vs_off;
               vd_off_q    <= adv_fields.vd_off;
               bank_q      <= adv_fields.bank;
            end
         end
      end
   end

   assign uop_valid       = uop_valid_q;
   assign uop_num         = num_q;
   assign uop_last        = uop_last_q;
   assign uop_lane_active = lanes_q;
   assign uop_elem_base   = base_q;
   assign uop_vs_reg_off  = vs_off_q;
   assign uop_vd_reg_off  = vd_off_q;
   assign uop_bank_offset = bank_q;
   assign illegal         = illegal_q;

endmodule

// File: tb/tb_vuop_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vuop_sequencer
//
// Directed bench for vuop_sequencer at VLEN=128, NUM_LANES=4 (EW=8, UW=5,
// BW=2). Expected values are hand-computed from the field definitions:
// epr = 128/(8<<vsew), vs_off = base/epr, vd_off = base/(epr>>widen),
// bank = (base mod epr)/4.
// -----------------------------------------------------------------------------
module tb_vuop_sequencer;

   logic       CLK = 1'b0;
   logic       RST;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_vsew;
   logic [2:0] in_vlmul;
   logic       in_widen;
   logic [7:0] in_vl;
   logic [7:0] in_vstart;
   logic       uop_valid;
   logic       uop_ready;
   logic [4:0] uop_num;
   logic       uop_last;
   logic [3:0] uop_lane_active;
   logic [7:0] uop_elem_base;
   logic [2:0] uop_vs_reg_off;
   logic [2:0] uop_vd_reg_off;
   logic [1:0] uop_bank_offset;
   logic       illegal;

   int n_checks = 0;
   int n_pass   = 0;

   vuop_sequencer #(.VLEN(128), .NUM_LANES(4)) dut (
      .CLK             (CLK),
      .RST             (RST),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_vsew         (in_vsew),
      .in_vlmul        (in_vlmul),
      .in_widen        (in_widen),
      .in_vl           (in_vl),
      .in_vstart       (in_vstart),
      .uop_valid       (uop_valid),
      .uop_ready       (uop_ready),
      .uop_num         (uop_num),
      .uop_last        (uop_last),
      .uop_lane_active (uop_lane_active),
      .uop_elem_base   (uop_elem_base),
      .uop_vs_reg_off  (uop_vs_reg_off),
      .uop_vd_reg_off  (uop_vd_reg_off),
      .uop_bank_offset (uop_bank_offset),
      .illegal         (illegal)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Land 1 time unit after the rising edge: registered outputs are settled.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Present an instruction, wait (bounded) for in_ready, take one edge.
   task automatic issue(input logic [2:0] sew, input logic [2:0] lmul, input logic wid,
                        input logic [7:0] vl, input logic [7:0] vst);
      int waited = 0;
      in_vsew   = sew;
      in_vlmul  = lmul;
      in_widen  = wid;
      in_vl     = vl;
      in_vstart = vst;
      in_valid  = 1'b1;
      #1;
      while (!in_ready && waited < 20) begin
         tick();
         #1;
         waited++;
      end
      check("issue_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic check_uop(input string tag, input logic [4:0] num, input logic [7:0] base,
                            input logic [3:0] lanes, input logic last, input logic [2:0] vs,
                            input logic [2:0] vd, input logic [1:0] bank);
      check({tag, "_valid"}, 32'(uop_valid), 32'd1);
      check({tag, "_num"},   32'(uop_num), 32'(num));
      check({tag, "_base"},  32'(uop_elem_base), 32'(base));
      check({tag, "_lanes"}, 32'(uop_lane_active), 32'(lanes));
      check({tag, "_last"},  32'(uop_last), 32'(last));
      check({tag, "_vs"},    32'(uop_vs_reg_off), 32'(vs));
      check({tag, "_vd"},    32'(uop_vd_reg_off), 32'(vd));
      check({tag, "_bank"},  32'(uop_bank_offset), 32'(bank));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      RST       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_vsew   = '0;
      in_vlmul  = '0;
      in_widen  = 1'b0;
      in_vl     = '0;
      in_vstart = '0;
      uop_ready = 1'b1;
      repeat (2) tick();
      RST = 1'b0;
      #1;

      // Reset state
      check("rst_valid",    32'(uop_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_num",      32'(uop_num), 32'd0);
      check("rst_last",     32'(uop_last), 32'd0);
      check("rst_lanes",    32'(uop_lane_active), 32'd0);
      check("rst_base",     32'(uop_elem_base), 32'd0);
      check("rst_vs",       32'(uop_vs_reg_off), 32'd0);
      check("rst_vd",       32'(uop_vd_reg_off), 32'd0);
      check("rst_bank",     32'(uop_bank_offset), 32'd0);
      check("rst_illegal",  32'(illegal), 32'd0);

      // SEW32 LMUL1 vl=4: one full uop
      issue(3'd2, 3'd0, 1'b0, 8'd4, 8'd0);
      check_uop("t1", 5'd0, 8'd0, 4'b1111, 1'b1, 3'd0, 3'd0, 2'd0);
      tick();
      check("t1_done", 32'(uop_valid), 32'd0);

      // SEW8 LMUL2 vl=30: epr=16, 8 uops, backpressure at uop 3
      issue(3'd0, 3'd1, 1'b0, 8'd30, 8'd0);
      for (int i = 0; i < 8; i++) begin
         check_uop($sformatf("t2_u%0d", i), 5'(i), 8'(4 * i),
                   (i == 7) ? 4'b0011 : 4'b1111, (i == 7),
                   3'(i / 4), 3'(i / 4), 2'(i % 4));
         if (i == 3) begin
            uop_ready = 1'b0;
            for (int h = 0; h < 3; h++) begin
               tick();
               check_uop($sformatf("t2_hold%0d", h), 5'd3, 8'd12, 4'b1111, 1'b0,
                         3'd0, 3'd0, 2'd3);
            end
            uop_ready = 1'b1;
         end
         tick();
      end
      check("t2_done", 32'(uop_valid), 32'd0);

      // SEW16 widen LMUL1 vl=8 vstart=5: epr=8, dest epr=4
`ifdef RV32V_VSTART_RESUME_EN
      issue(3'd1, 3'd0, 1'b1, 8'd8, 8'd5);
      // Only base 4 is emitted; elements 5..7 active; vd = 4/4 = 1.
      check_uop("t3", 5'd0, 8'd4, 4'b1110, 1'b1, 3'd0, 3'd1, 2'd1);
      tick();
`else
      issue(3'd1, 3'd0, 1'b1, 8'd8, 8'd5);
      check_uop("t3_u0", 5'd0, 8'd0, 4'b1111, 1'b0, 3'd0, 3'd0, 2'd0);
      tick();
      check_uop("t3_u1", 5'd1, 8'd4, 4'b1111, 1'b1, 3'd0, 3'd1, 2'd1);
      tick();
`endif
      check("t3_done", 32'(uop_valid), 32'd0);

      // vl=0: single empty uop
      issue(3'd2, 3'd0, 1'b0, 8'd0, 8'd0);
      check_uop("t4", 5'd0, 8'd0, 4'b0000, 1'b1, 3'd0, 3'd0, 2'd0);
      tick();
      check("t4_done", 32'(uop_valid), 32'd0);

      // SEW64: illegal, no uop
      issue(3'd3, 3'd0, 1'b0, 8'd4, 8'd0);
      check("t5_illegal",  32'(illegal), 32'd1);
      check("t5_valid",    32'(uop_valid), 32'd0);
      check("t5_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("t5_pulse_end", 32'(illegal), 32'd0);
      check("t5_no_uop",    32'(uop_valid), 32'd0);

      // LMUL8 with widen: illegal
      issue(3'd0, 3'd3, 1'b1, 8'd4, 8'd0);
      check("t5b_illegal", 32'(illegal), 32'd1);
      check("t5b_valid",   32'(uop_valid), 32'd0);
      tick();

      // Flush during uop 2 of 8, with a competing instruction offered
      issue(3'd0, 3'd1, 1'b0, 8'd30, 8'd0);
      tick();
      tick();
      check("t6_num2", 32'(uop_num), 32'd2);
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_vsew   = 3'd2;
      in_vlmul  = 3'd0;
      in_widen  = 1'b0;
      in_vl     = 8'd4;
      in_vstart = 8'd0;
      #1;
      check("t6_ready_gated", 32'(in_ready), 32'd0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("t6_flushed",  32'(uop_valid), 32'd0);
      check("t6_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("t6_not_taken", 32'(uop_valid), 32'd0);

      // Back-to-back: SEW32 LMUL2 vl=8 (epr=4), next accepted on last handshake
      issue(3'd2, 3'd1, 1'b0, 8'd8, 8'd0);
      check_uop("t7_u0", 5'd0, 8'd0, 4'b1111, 1'b0, 3'd0, 3'd0, 2'd0);
      tick();
      check_uop("t7_u1", 5'd1, 8'd4, 4'b1111, 1'b1, 3'd1, 3'd1, 2'd0);
      in_vsew   = 3'd2;
      in_vlmul  = 3'd0;
      in_widen  = 1'b0;
      in_vl     = 8'd4;
      in_vstart = 8'd0;
      in_valid  = 1'b1;
      #1;
      check("t7_ready_on_last", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check_uop("t7_next", 5'd0, 8'd0, 4'b1111, 1'b1, 3'd0, 3'd0, 2'd0);
      tick();
      check("t7_done", 32'(uop_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
